// File: rtl/scr1_tapc_dr_shift_update.sv
`default_nettype none
// ---------------------------------------------------------------------------
// scr1_tapc_dr_shift_update : JTAG DR stage with shadow update register,
// runtime length/direction and shift-count-validated commit.  Rev 1.0
// ---------------------------------------------------------------------------
module scr1_tapc_dr_shift_update #(
  parameter int                    SCR1_WIDTH           = 32,
  parameter logic [SCR1_WIDTH-1:0] SCR1_RESET_VALUE     = '0,
  parameter logic [SCR1_WIDTH-1:0] SCR1_UPD_RESET_VALUE = '0,
  parameter bit                    SCR1_STRICT_LEN      = 1'b1,
  parameter int                    SCR1_LEN_W           = $clog2(SCR1_WIDTH+1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fsm_dr_select,
  input  logic                  fsm_dr_capture,
  input  logic                  fsm_dr_shift,
  input  logic                  fsm_dr_update,
  input  logic [SCR1_LEN_W-1:0] cfg_len,
  input  logic                  cfg_msb_first,
  input  logic                  din_serial,
  input  logic [SCR1_WIDTH-1:0] din_parallel,
  output logic                  dout_serial,
  output logic [SCR1_WIDTH-1:0] dout_parallel,
  output logic [SCR1_WIDTH-1:0] upd_data,
  output logic                  upd_valid,
  output logic                  upd_err,
  output logic [SCR1_LEN_W:0]   shift_cnt
);

  localparam logic [SCR1_LEN_W-1:0] WIDTH_L = SCR1_LEN_W'(SCR1_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CAPTURED = 2'd1,
    ST_SHIFTING = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [SCR1_WIDTH-1:0]   sr_q, sr_d;
  logic [SCR1_WIDTH-1:0]   upd_data_q, upd_data_d;
  logic                    upd_valid_q, upd_valid_d;
  logic                    upd_err_q, upd_err_d;
  logic [SCR1_LEN_W:0]     shift_cnt_q, shift_cnt_d;
  logic [SCR1_LEN_W-1:0]   len_q, len_d;
  logic                    msb_q, msb_d;

  logic [SCR1_LEN_W-1:0]   len_eff;
  logic [SCR1_WIDTH-1:0]   sr_up;
  logic [SCR1_WIDTH-1:0]   sr_dn;
  logic [SCR1_WIDTH-1:0]   len_mask;
  logic                    top_bit;

  // Out-of-range or zero length selects the full register.
  assign len_eff = ((cfg_len == '0) || (cfg_len > WIDTH_L)) ? WIDTH_L : cfg_len;

  assign sr_up = {sr_q[SCR1_WIDTH-2:0], din_serial};
  assign sr_dn = {din_serial, sr_q[SCR1_WIDTH-1:1]};

  always_comb begin
    len_mask = '0;
    top_bit  = sr_q[0];
    for (int i = 0; i < SCR1_WIDTH; i++) begin
      len_mask[i] = (i < int'(len_q));
      if (i == int'(len_q) - 1) begin
        top_bit = sr_q[i];
      end
    end
  end

  assign dout_serial   = msb_q ? top_bit : sr_q[0];
  assign dout_parallel = sr_q;
  assign upd_data      = upd_data_q;
  assign upd_valid     = upd_valid_q;
  assign upd_err       = upd_err_q;
  assign shift_cnt     = shift_cnt_q;

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    upd_data_d  = upd_data_q;
    upd_valid_d = 1'b0;
    upd_err_d   = 1'b0;
    shift_cnt_d = shift_cnt_q;
    len_d       = len_q;
    msb_d       = msb_q;

    if (fsm_dr_select) begin
      if (fsm_dr_capture) begin
        sr_d        = din_parallel;
        shift_cnt_d = '0;
        len_d       = len_eff;
        msb_d       = cfg_msb_first;
        state_d     = ST_CAPTURED;
      end else if (fsm_dr_shift) begin
        // Only the low len_q bits move; the upper bits keep their value.
        for (int i = 0; i < SCR1_WIDTH; i++) begin
          if (len_mask[i]) begin
            if (msb_q) begin
              sr_d[i] = sr_up[i];
            end else if (i == int'(len_q) - 1) begin
              sr_d[i] = din_serial;
            end else begin
              sr_d[i] = sr_dn[i];
            end
          end
        end
        if (shift_cnt_q != '1) begin
          shift_cnt_d = shift_cnt_q + 1'b1;
        end
        if (state_q != ST_IDLE) begin
          state_d = ST_SHIFTING;
        end
      end else if (fsm_dr_update) begin
        if (state_q == ST_IDLE) begin
          upd_err_d = 1'b1;
        end else if (SCR1_STRICT_LEN && (shift_cnt_q != {1'b0, len_q})) begin
          upd_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          upd_data_d  = sr_q & len_mask;
          upd_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sr_q        <= SCR1_RESET_VALUE;
      upd_data_q  <= SCR1_UPD_RESET_VALUE;
      upd_valid_q <= 1'b0;
      upd_err_q   <= 1'b0;
      shift_cnt_q <= '0;
      len_q       <= WIDTH_L;
      msb_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      upd_data_q  <= upd_data_d;
      upd_valid_q <= upd_valid_d;
      upd_err_q   <= upd_err_d;
      shift_cnt_q <= shift_cnt_d;
      len_q       <= len_d;
      msb_q       <= msb_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_scr1_tapc_dr_shift_update.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_scr1_tapc_dr_shift_update : directed bench for the DR stage (WIDTH=8),
// strict and non-strict instances driven in parallel.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_scr1_tapc_dr_shift_update;

  localparam int W  = 8;
  localparam int LW = $clog2(W+1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sel, cap, shf, upd;
  logic [LW-1:0] cfg_len;
  logic          cfg_msb;
  logic          din_s;
  logic [W-1:0]  din_p;

  logic          dout_s, ns_dout_s;
  logic [W-1:0]  dout_p, ns_dout_p;
  logic [W-1:0]  upd_data, ns_upd_data;
  logic          upd_valid, ns_upd_valid;
  logic          upd_err, ns_upd_err;
  logic [LW:0]   shift_cnt, ns_shift_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  scr1_tapc_dr_shift_update #(.SCR1_WIDTH(W), .SCR1_STRICT_LEN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .fsm_dr_select(sel), .fsm_dr_capture(cap),
    .fsm_dr_shift(shf), .fsm_dr_update(upd), .cfg_len(cfg_len),
    .cfg_msb_first(cfg_msb), .din_serial(din_s), .din_parallel(din_p),
    .dout_serial(dout_s), .dout_parallel(dout_p), .upd_data(upd_data),
    .upd_valid(upd_valid), .upd_err(upd_err), .shift_cnt(shift_cnt)
  );

  scr1_tapc_dr_shift_update #(.SCR1_WIDTH(W), .SCR1_STRICT_LEN(1'b0)) u_dut_ns (
    .clk(clk), .rst_n(rst_n), .fsm_dr_select(sel), .fsm_dr_capture(cap),
    .fsm_dr_shift(shf), .fsm_dr_update(upd), .cfg_len(cfg_len),
    .cfg_msb_first(cfg_msb), .din_serial(din_s), .din_parallel(din_p),
    .dout_serial(ns_dout_s), .dout_parallel(ns_dout_p), .upd_data(ns_upd_data),
    .upd_valid(ns_upd_valid), .upd_err(ns_upd_err), .shift_cnt(ns_shift_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [W-1:0] data, input logic [LW-1:0] len, input logic msb);
    din_p   = data;
    cfg_len = len;
    cfg_msb = msb;
    cap     = 1'b1;
    tick();
    cap     = 1'b0;
  endtask

  task automatic shift_bit(input logic b, input logic exp_dout, input string tag);
    din_s = b;
    shf   = 1'b1;
    check(tag, 32'(dout_s), 32'(exp_dout));
    tick();
    shf   = 1'b0;
  endtask

  task automatic do_update();
    upd = 1'b1;
    tick();
    upd = 1'b0;
  endtask

  logic [7:0] t2_din  = 8'b0011_0001;
  logic [7:0] t2_dout = 8'b1010_0101;
  logic [3:0] t3_din  = 4'b1101;
  logic [3:0] t3_dout = 4'b0110;

  initial begin
    rst_n = 1'b0; sel = 1'b1; cap = 1'b1; shf = 1'b0; upd = 1'b0;
    cfg_len = '0; cfg_msb = 1'b0; din_s = 1'b0; din_p = 8'hFF;

    // Reset wins over a concurrent capture
    tick(); tick();
    check("rst_sr",    32'(dout_p),    32'h00);
    check("rst_upd",   32'(upd_data),  32'h00);
    check("rst_cnt",   32'(shift_cnt), 32'h0);
    check("rst_valid", 32'(upd_valid), 32'h0);
    check("rst_err",   32'(upd_err),   32'h0);
    cap = 1'b0; rst_n = 1'b1;
    tick();

    // LSB-first full length
    capture(8'hA5, 4'd0, 1'b0);
    check("t2_cap_sr",  32'(dout_p),    32'hA5);
    check("t2_cap_cnt", 32'(shift_cnt), 32'h0);
    for (int i = 0; i < 8; i++) shift_bit(t2_din[i], t2_dout[i], "t2_dout");
    check("t2_sr",  32'(dout_p),    32'h31);
    check("t2_cnt", 32'(shift_cnt), 32'd8);
    do_update();
    check("t2_upd",   32'(upd_data),  32'h31);
    check("t2_valid", 32'(upd_valid), 32'h1);
    check("t2_err",   32'(upd_err),   32'h0);
    tick();
    check("t2_valid_pulse", 32'(upd_valid), 32'h0);
    check("t2_upd_hold",    32'(upd_data),  32'h31);

    // MSB-first, length 4
    capture(8'hF6, 4'd4, 1'b1);
    for (int i = 0; i < 4; i++) shift_bit(t3_din[i], t3_dout[i], "t3_dout");
    check("t3_sr", 32'(dout_p), 32'hFB);
    do_update();
    check("t3_upd",   32'(upd_data),  32'h0B);
    check("t3_valid", 32'(upd_valid), 32'h1);

    // Short shift: strict rejects, non-strict commits
    capture(8'h0F, 4'd4, 1'b0);
    for (int i = 0; i < 3; i++) shift_bit(1'b0, 1'b1, "t4a_dout");
    do_update();
    check("t4a_err",      32'(upd_err),      32'h1);
    check("t4a_valid",    32'(upd_valid),    32'h0);
    check("t4a_upd",      32'(upd_data),     32'h0B);
    check("t4a_ns_valid", 32'(ns_upd_valid), 32'h1);
    check("t4a_ns_upd",   32'(ns_upd_data),  32'h01);
    tick();
    check("t4a_err_pulse", 32'(upd_err), 32'h0);

    // Long shift: strict rejects
    capture(8'h0F, 4'd4, 1'b0);
    for (int i = 0; i < 5; i++) shift_bit(1'b0, (i < 4) ? 1'b1 : 1'b0, "t4b_dout");
    check("t4b_cnt", 32'(shift_cnt), 32'd5);
    do_update();
    check("t4b_err",    32'(upd_err),     32'h1);
    check("t4b_valid",  32'(upd_valid),   32'h0);
    check("t4b_upd",    32'(upd_data),    32'h0B);
    check("t4b_ns_upd", 32'(ns_upd_data), 32'h00);
    // Second update with no fresh capture
    do_update();
    check("t4c_err",    32'(ns_upd_err),   32'h1);
    check("t4c_valid",  32'(ns_upd_valid), 32'h0);

    // Capture beats shift
    din_p = 8'h5A; cfg_len = '0; cfg_msb = 1'b0; cap = 1'b1; shf = 1'b1; din_s = 1'b1;
    tick();
    cap = 1'b0; shf = 1'b0;
    check("t5_pri_sr",  32'(dout_p),    32'h5A);
    check("t5_pri_cnt", 32'(shift_cnt), 32'h0);
    shift_bit(1'b1, 1'b0, "t5_dout");
    check("t5_sr", 32'(dout_p), 32'hAD);

    // Deselected: nothing moves
    sel = 1'b0; din_p = 8'hFF;
    cap = 1'b1; tick(); cap = 1'b0;
    shf = 1'b1; tick(); shf = 1'b0;
    upd = 1'b1; tick(); upd = 1'b0;
    check("t5_sel_sr",    32'(dout_p),    32'hAD);
    check("t5_sel_cnt",   32'(shift_cnt), 32'h1);
    check("t5_sel_err",   32'(upd_err),   32'h0);
    check("t5_sel_valid", 32'(upd_valid), 32'h0);
    check("t5_sel_upd",   32'(upd_data),  32'h0B);
    sel = 1'b1;

    // Length latched at capture only
    capture(8'h00, 4'd4, 1'b0);
    cfg_len = 4'd8;
    for (int i = 0; i < 4; i++) shift_bit(1'b1, 1'b0, "t5_len_dout");
    check("t5_len_sr", 32'(dout_p), 32'h0F);
    do_update();
    check("t5_len_valid", 32'(upd_valid), 32'h1);
    check("t5_len_upd",   32'(upd_data),  32'h0F);

    // Reset mid-shift
    capture(8'h3C, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) shift_bit(1'b0, (i < 2) ? 1'b0 : 1'b1, "t6_dout");
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("t6_sr",  32'(dout_p),    32'h00);
    check("t6_cnt", 32'(shift_cnt), 32'h0);
    do_update();
    check("t6_err",   32'(upd_err),   32'h1);
    check("t6_valid", 32'(upd_valid), 32'h0);
    check("t6_upd",   32'(upd_data),  32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
